// File: rtl/prog_cnt_pkg.sv
// prog_cnt shared types, constants and parameter-legality check.
// Optional feature macro: PRESCALE_EN (see prog_cnt.sv).
package prog_cnt_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic bit params_ok(
        input int width,
        input int modv,
        input int rst_val,
        input int pre_div
    );
        return (modv >= 2) && (modv <= (1 << width)) &&
               (rst_val >= 0) && (rst_val < modv) &&
               (pre_div >= 2);
    endfunction

endpackage

`ifndef PROG_CNT_CHECK
`define PROG_CNT_CHECK(W, M, R, P) \
    if (!prog_cnt_pkg::params_ok(W, M, R, P)) begin : g_bad_params \
        $error("prog_cnt: illegal parameters"); \
    end
`endif

// File: rtl/cnt_prescale.sv
// Divide-by-PRE_DIV tick generator for prog_cnt.
// Instantiated only when PRESCALE_EN is defined.
module cnt_prescale #(
    parameter int PRE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int DW = $clog2(PRE_DIV);
    localparam logic [DW-1:0] LAST = DW'(PRE_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (clr) begin
            div <= '0;
        end else if (run) begin
            div <= (div == LAST) ? '0 : div + 1'b1;
        end
    end

    assign tick = run && (div == LAST);

endmodule

// File: rtl/prog_cnt.sv
// Programmable up/down counter with wrap/saturate and one-shot run.
// Define PRESCALE_EN to gate stepping with a divide-by-PRE_DIV tick.
module prog_cnt
    import prog_cnt_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int MOD     = 64,
    parameter int RST_VAL = 0,
    parameter int PRE_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [WIDTH-1:0] len,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc,
    output logic             wrap_p,
    output logic             busy,
    output logic             done_p
);

    `PROG_CNT_CHECK(WIDTH, MOD, RST_VAL, PRE_DIV)

    localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] TOPV = MAXV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH-1:0] ld_v;
    logic [WIDTH-1:0] nxt;
    logic             wrap_n;
    logic             at_top;
    logic             at_bot;
    logic             dn;
    logic             accept;
    logic             step_ok;

    // Compare one bit wider so MOD == 2**WIDTH needs no special case
    assign cnt_x  = {1'b0, cnt_o};
    assign at_top = (cnt_x == MAXV);
    assign at_bot = (cnt_x == '0);
    assign dn     = (up_dn == DIR_DN);
    assign ld_v   = ({1'b0, load_val} > MAXV) ? TOPV : load_val;
    assign tc     = dn ? at_bot : at_top;
    assign busy   = (state == ST_RUN);
    assign accept = start && (state == ST_IDLE);

`ifdef PRESCALE_EN
    logic tick;

    cnt_prescale #(
        .PRE_DIV(PRE_DIV)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .clr (clr | load | accept),
        .run (busy | en),
        .tick(tick)
    );

    assign step_ok = (busy | en) & tick;
`else
    assign step_ok = busy | en;
`endif

    always_comb begin
        nxt    = cnt_o;
        wrap_n = 1'b0;
        unique case (1'b1)
            (!dn && !at_top): nxt = cnt_o + 1'b1;
            (!dn && at_top && !sat): begin
                nxt    = '0;
                wrap_n = 1'b1;
            end
            (dn && !at_bot): nxt = cnt_o - 1'b1;
            (dn && at_bot && !sat): begin
                nxt    = TOPV;
                wrap_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_o  <= RSTV;
            wrap_p <= 1'b0;
            done_p <= 1'b0;
            state  <= ST_IDLE;
            rem    <= '0;
        end else begin
            wrap_p <= 1'b0;
            done_p <= 1'b0;
            if (clr) begin
                cnt_o <= '0;
                state <= ST_IDLE;
            end else if (load) begin
                cnt_o <= ld_v;
            end else if (accept) begin
                if (len == '0) begin
                    done_p <= 1'b1;
                end else begin
                    state <= ST_RUN;
                    rem   <= len;
                end
            end else if (step_ok) begin
                cnt_o  <= nxt;
                wrap_p <= wrap_n;
                // A saturated hold still burns a step so runs always end
                if (busy) begin
                    rem <= rem - 1'b1;
                    if (rem == WIDTH'(1)) begin
                        done_p <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_cnt.sv
// Self-checking bench for prog_cnt: MOD=64 and MOD=10 instances.
// Hand-built vector table fed through an expected-result queue.
module tb_prog_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up_dn = 1'b0, sat = 1'b0;
    logic       clr = 1'b0, load = 1'b0, start = 1'b0;
    logic [5:0] load_val = '0, len = '0;

    logic [5:0] cnt_a, cnt_b;
    logic       tc_a, wrap_a, busy_a, done_a;
    logic       tc_b, wrap_b, busy_b, done_b;

    prog_cnt u_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat),
        .clr(clr), .load(load), .load_val(load_val),
        .start(start), .len(len), .cnt_o(cnt_a), .tc(tc_a),
        .wrap_p(wrap_a), .busy(busy_a), .done_p(done_a)
    );

    prog_cnt #(.WIDTH(6), .MOD(10), .RST_VAL(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat),
        .clr(clr), .load(load), .load_val(load_val),
        .start(start), .len(len), .cnt_o(cnt_b), .tc(tc_b),
        .wrap_p(wrap_b), .busy(busy_b), .done_p(done_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         sel;
        logic       en, up, sat, clr, load, start;
        logic [5:0] lv, ln;
        logic [5:0] e_cnt;
        logic       e_tc, e_wrap, e_busy, e_done;
    } vec_t;

    vec_t vecs[$];
    vec_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input string nm, input bit sel,
        input bit e, input bit u, input bit s,
        input bit c, input bit l, input int lv,
        input bit st, input int ln,
        input int cnt, input bit t, input bit w,
        input bit b, input bit d
    );
        vec_t v;
        v.name = nm; v.sel = sel;
        v.en = e; v.up = u; v.sat = s; v.clr = c; v.load = l;
        v.lv = 6'(lv); v.start = st; v.ln = 6'(ln);
        v.e_cnt = 6'(cnt); v.e_tc = t; v.e_wrap = w;
        v.e_busy = b; v.e_done = d;
        return v;
    endfunction

    task automatic check_out(input vec_t v);
        logic [5:0] c;
        logic t, w, b, d;
        c = v.sel ? cnt_b : cnt_a;
        t = v.sel ? tc_b : tc_a;
        w = v.sel ? wrap_b : wrap_a;
        b = v.sel ? busy_b : busy_a;
        d = v.sel ? done_b : done_a;
        checks++;
        if (c !== v.e_cnt || t !== v.e_tc || w !== v.e_wrap ||
            b !== v.e_busy || d !== v.e_done) begin
            errors++;
            $display("FAIL %s dut%0d: got cnt=%0d tc=%b wrap=%b busy=%b done=%b want cnt=%0d tc=%b wrap=%b busy=%b done=%b",
                     v.name, v.sel, c, t, w, b, d,
                     v.e_cnt, v.e_tc, v.e_wrap, v.e_busy, v.e_done);
        end
    endtask

    task automatic apply(input vec_t v);
        en = v.en; up_dn = v.up; sat = v.sat;
        clr = v.clr; load = v.load; load_val = v.lv;
        start = v.start; len = v.ln;
        sbq.push_back(v);
        @(posedge clk);
        #1;
        check_out(sbq.pop_front());
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();
    endtask

    task automatic idle_inputs();
        en = 0; up_dn = 0; sat = 0; clr = 0;
        load = 0; start = 0; load_val = '0; len = '0;
    endtask

    task automatic check_rst(input string nm);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ((s == 0 && {cnt_a, wrap_a, busy_a, done_a} !== 9'd0) ||
                (s == 1 && {cnt_b, wrap_b, busy_b, done_b} !== 9'd0)) begin
                errors++;
                $display("FAIL %s dut%0d: got cnt=%0d wrap=%b busy=%b done=%b want all 0",
                         nm, s,
                         s == 0 ? cnt_a : cnt_b,
                         s == 0 ? wrap_a : wrap_b,
                         s == 0 ? busy_a : busy_b,
                         s == 0 ? done_a : done_b);
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check_rst("reset");
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
`ifdef PRESCALE_EN
        for (int k = 1; k <= 10; k++)
            vecs.push_back(mk("pre_up", 0, 1,1,0, 0,0,0, 0,0,
                              k / 4, 0,0,0,0));
        vecs.push_back(mk("pre_load", 0, 1,1,0, 0,1,30, 0,0,
                          30, 0,0,0,0));
        for (int m = 1; m <= 9; m++)
            vecs.push_back(mk("pre_after_ld", 0, 1,1,0, 0,0,0, 0,0,
                              30 + m / 4, 0,0,0,0));
        run_vecs();
`else
        // 64-state down-count with wrap, then direction change
        vecs.push_back(mk("dn_wrap", 0, 1,0,0, 0,0,0, 0,0, 63, 0,1,0,0));
        vecs.push_back(mk("dn_62",   0, 1,0,0, 0,0,0, 0,0, 62, 0,0,0,0));
        vecs.push_back(mk("dn_61",   0, 1,0,0, 0,0,0, 0,0, 61, 0,0,0,0));
        vecs.push_back(mk("dn_60",   0, 1,0,0, 0,0,0, 0,0, 60, 0,0,0,0));
        vecs.push_back(mk("dir_up",  0, 1,1,0, 0,0,0, 0,0, 61, 0,0,0,0));
        vecs.push_back(mk("ld_63",   0, 0,1,0, 0,1,63, 0,0, 63, 1,0,0,0));
        vecs.push_back(mk("up_wrap", 0, 1,1,0, 0,0,0, 0,0, 0, 0,1,0,0));
        run_vecs();

        // 10-state saturating climb
        do_reset();
        for (int k = 1; k <= 15; k++)
            vecs.push_back(mk("sat_up", 1, 1,1,1, 0,0,0, 0,0,
                              (k < 9) ? k : 9, k >= 9, 0,0,0));
        // clear, clamped load, clr beats load, mod-10 wraps
        vecs.push_back(mk("clr",      1, 1,1,0, 1,0,0, 0,0, 0, 0,0,0,0));
        vecs.push_back(mk("ld_clamp", 1, 0,1,0, 0,1,12, 0,0, 9, 1,0,0,0));
        vecs.push_back(mk("clr_ld",   1, 0,1,0, 1,1,12, 0,0, 0, 0,0,0,0));
        vecs.push_back(mk("ld_7",     1, 0,1,0, 0,1,7, 0,0, 7, 0,0,0,0));
        vecs.push_back(mk("up_8",     1, 1,1,0, 0,0,0, 0,0, 8, 0,0,0,0));
        vecs.push_back(mk("up_9",     1, 1,1,0, 0,0,0, 0,0, 9, 1,0,0,0));
        vecs.push_back(mk("m10_wrap", 1, 1,1,0, 0,0,0, 0,0, 0, 0,1,0,0));
        vecs.push_back(mk("up_1",     1, 1,1,0, 0,0,0, 0,0, 1, 0,0,0,0));
        vecs.push_back(mk("dn_0",     1, 1,0,0, 0,0,0, 0,0, 0, 1,0,0,0));
        vecs.push_back(mk("m10_dwrap",1, 1,0,0, 0,0,0, 0,0, 9, 0,1,0,0));
        // one-shot runs
        vecs.push_back(mk("os_ld3",   1, 0,1,0, 0,1,3, 0,0, 3, 0,0,0,0));
        vecs.push_back(mk("os_start", 1, 0,1,0, 0,0,0, 1,5, 3, 0,0,1,0));
        vecs.push_back(mk("os_s1",    1, 0,1,0, 0,0,0, 0,0, 4, 0,0,1,0));
        vecs.push_back(mk("os_s2_st", 1, 0,1,0, 0,0,0, 1,2, 5, 0,0,1,0));
        vecs.push_back(mk("os_s3",    1, 0,1,0, 0,0,0, 0,0, 6, 0,0,1,0));
        vecs.push_back(mk("os_s4",    1, 0,1,0, 0,0,0, 0,0, 7, 0,0,1,0));
        vecs.push_back(mk("os_done",  1, 0,1,0, 0,0,0, 0,0, 8, 0,0,0,1));
        vecs.push_back(mk("os_idle",  1, 0,1,0, 0,0,0, 0,0, 8, 0,0,0,0));
        vecs.push_back(mk("len0",     1, 0,1,0, 0,0,0, 1,0, 8, 0,0,0,1));
        vecs.push_back(mk("len0_aft", 1, 0,1,0, 0,0,0, 0,0, 8, 0,0,0,0));
        vecs.push_back(mk("ld_st",    1, 0,1,0, 0,1,2, 1,3, 2, 0,0,0,0));
        vecs.push_back(mk("ld_st_aft",1, 0,1,0, 0,0,0, 0,0, 2, 0,0,0,0));
        // saturated hold inside a run still terminates
        vecs.push_back(mk("sr_ld8",   1, 0,1,1, 0,1,8, 0,0, 8, 0,0,0,0));
        vecs.push_back(mk("sr_start", 1, 0,1,1, 0,0,0, 1,3, 8, 0,0,1,0));
        vecs.push_back(mk("sr_9",     1, 0,1,1, 0,0,0, 0,0, 9, 1,0,1,0));
        vecs.push_back(mk("sr_hold",  1, 0,1,1, 0,0,0, 0,0, 9, 1,0,1,0));
        vecs.push_back(mk("sr_done",  1, 0,1,1, 0,0,0, 0,0, 9, 1,0,0,1));
        // clr aborts a run without done_p
        vecs.push_back(mk("ab_start", 1, 0,1,0, 0,0,0, 1,4, 9, 1,0,1,0));
        vecs.push_back(mk("ab_wrap",  1, 0,1,0, 0,0,0, 0,0, 0, 0,1,1,0));
        vecs.push_back(mk("ab_clr",   1, 0,1,0, 1,0,0, 0,0, 0, 0,0,0,0));
        vecs.push_back(mk("ab_after", 1, 0,1,0, 0,0,0, 0,0, 0, 0,0,0,0));
        run_vecs();

        // async reset in the middle of a run at cnt_o=20
        do_reset();
        vecs.push_back(mk("ar_ld",    0, 0,1,0, 0,1,18, 0,0, 18, 0,0,0,0));
        vecs.push_back(mk("ar_start", 0, 0,1,0, 0,0,0, 1,10, 18, 0,0,1,0));
        vecs.push_back(mk("ar_19",    0, 0,1,0, 0,0,0, 0,0, 19, 0,0,1,0));
        vecs.push_back(mk("ar_20",    0, 0,1,0, 0,0,0, 0,0, 20, 0,0,1,0));
        run_vecs();
        #2;
        rst = 0;
        #1;
        checks++;
        if (cnt_a !== 6'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: got cnt=%0d busy=%b done=%b want 0 0 0",
                     cnt_a, busy_a, done_a);
        end
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 12; k++)
            vecs.push_back(mk("post_rst", 0, 0,1,0, 0,0,0, 0,0,
                              0, 0,0,0,0));
        run_vecs();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
